id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/flopenrc.sv | 23 ++
 rtl/id_ex_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_reg.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings and the ID/EX control bundle.
package riscv_pkg;

    typedef enum logic [1:0] {
        ResultAlu = 2'b00,
        ResultMem = 2'b01,
        ResultPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic [1:0] resultsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned REGIDX_W = 15;

    // A load in EX whose destination feeds either source of the decode instruction.
    function automatic logic load_hazard(input ctrl_t ctrl_e, input logic [4:0] rd_e,
                                         input logic [4:0] rs1_d, input logic [4:0] rs2_d);
        return ctrl_e.valid && (ctrl_e.resultsrc == ResultMem) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/flopenrc.sv
// Enabled register with synchronous clear and asynchronous active-low reset.
module flopenrc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall and combinational load-use detection.
// Optional bubble counter enabled by defining IDEX_PERF_CNT_EN.
module id_ex_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PCW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EnE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [PCW-1:0]  PCD,
    input  logic [PCW-1:0]  PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [PCW-1:0]  PCE,
    output logic [PCW-1:0]  PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            LoadUseD
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]     BubbleCntE
`endif
);

    localparam int unsigned DATA_W = 3 * XLEN + 2 * PCW;

    ctrl_t                ctrl_d, ctrl_q;
    logic [REGIDX_W-1:0]  idx_q;
    logic [DATA_W-1:0]    data_q;
    logic                 bubble_load;
    logic                 ctrl_en;
    logic                 data_en;

    // Flush wins over stall; an invalid decode slot only bubbles when the register loads.
    assign bubble_load = FlushE || (EnE && !ValidD);
    assign ctrl_en     = EnE || FlushE;
    // Data/PC fields are don't-care in a bubble, so they simply hold.
    assign data_en     = EnE && !FlushE && ValidD;

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = ValidD;
        ctrl_d.regwrite   = RegWriteD;
        ctrl_d.memwrite   = MemWriteD;
        ctrl_d.jump       = JumpD;
        ctrl_d.branch     = BranchD;
        ctrl_d.alusrc     = ALUSrcD;
        ctrl_d.resultsrc  = ResultSrcD;
        ctrl_d.alucontrol = ALUControlD;
    end

    flopenrc #(.WIDTH(CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_en),
        .clr   (bubble_load),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    flopenrc #(.WIDTH(REGIDX_W)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_en),
        .clr   (bubble_load),
        .d     ({Rs1D, Rs2D, RdD}),
        .q     (idx_q)
    );

    flopenrc #(.WIDTH(DATA_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (data_en),
        .clr   (1'b0),
        .d     ({RD1D, RD2D, ImmExtD, PCD, PCPlus4D}),
        .q     (data_q)
    );

    assign ValidE      = ctrl_q.valid;
    assign RegWriteE   = ctrl_q.regwrite;
    assign MemWriteE   = ctrl_q.memwrite;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alusrc;
    assign ResultSrcE  = ctrl_q.resultsrc;
    assign ALUControlE = ctrl_q.alucontrol;
    assign {Rs1E, Rs2E, RdE} = idx_q;
    assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E} = data_q;

    assign LoadUseD = load_hazard(ctrl_q, RdE, Rs1D, Rs2D);

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; counter checks run when IDEX_PERF_CNT_EN is defined.
module tb_id_ex_reg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 32;

    logic            clk;
    logic            rst_n;
    logic            EnE, FlushE, ValidD;
    logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
    logic [PCW-1:0]  PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE;
    logic [PCW-1:0]  PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            LoadUseD;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0]     BubbleCntE;
`endif

    int checks;
    int fails;

    id_ex_reg #(.XLEN(XLEN), .PCW(PCW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .EnE         (EnE),
        .FlushE      (FlushE),
        .ValidD      (ValidD),
        .RegWriteD   (RegWriteD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ResultSrcD  (ResultSrcD),
        .ALUControlD (ALUControlD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .ValidE      (ValidE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .LoadUseD    (LoadUseD)
`ifdef IDEX_PERF_CNT_EN
        ,
        .BubbleCntE  (BubbleCntE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All E outputs concatenated, 11 + 96 + 64 + 15 = 186 bits.
    function automatic logic [185:0] all_e();
        return {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic v);
        ValidD = v; RegWriteD = v; MemWriteD = v; JumpD = v; BranchD = v; ALUSrcD = v;
        ResultSrcD = {2{v}}; ALUControlD = {3{v}};
        RD1D = {XLEN{v}}; RD2D = {XLEN{v}}; ImmExtD = {XLEN{v}};
        PCD = {PCW{v}}; PCPlus4D = {PCW{v}};
        Rs1D = {5{v}}; Rs2D = {5{v}}; RdD = {5{v}};
    endtask

    task automatic test_reset();
        EnE = 1'b1; FlushE = 1'b0;
        drive_all(1'b0);
        rst_n = 1'b0;
        #12;
        checks++;
        if (all_e() !== '0) begin
            fails++; $display("FAIL reset_initial: got %h want 0", all_e());
        end
        rst_n = 1'b1;
        drive_all(1'b1);
        step();
        checks++;
        if (all_e() !== {186{1'b1}}) begin
            fails++; $display("FAIL load_all_ones: got %h want all ones", all_e());
        end
        // Async assertion mid-cycle, inputs still all ones.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_e() !== '0) begin
            fails++; $display("FAIL reset_async: got %h want 0", all_e());
        end
        checks++;
        if (LoadUseD !== 1'b0) begin
            fails++; $display("FAIL reset_loaduse: got %b want 0", LoadUseD);
        end
        step();
        rst_n = 1'b1;
        drive_all(1'b0);
    endtask

    task automatic test_load();
        drive_all(1'b0);
        ValidD = 1'b1; RegWriteD = 1'b1; RdD = 5'd5; RD1D = 32'h1234; PCD = 32'h100;
        EnE = 1'b1; FlushE = 1'b0;
        step();
        checks++;
        if (RegWriteE !== 1'b1 || RdE !== 5'd5 || ValidE !== 1'b1) begin
            fails++;
            $display("FAIL load_ctrl: got rw=%b rd=%0d v=%b want 1 5 1", RegWriteE, RdE, ValidE);
        end
        checks++;
        if (RD1E !== 32'h1234 || PCE !== 32'h100) begin
            fails++; $display("FAIL load_data: got rd1=%h pc=%h want 1234 100", RD1E, PCE);
        end
    endtask

    task automatic test_stall_flush();
        EnE = 1'b0;
        RdD = 5'd12; RD1D = 32'hDEAD; RegWriteD = 1'b0;
        step();
        step();
        checks++;
        if (RdE !== 5'd5 || RD1E !== 32'h1234 || RegWriteE !== 1'b1 || ValidE !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold: got rd=%0d rd1=%h rw=%b v=%b want 5 1234 1 1",
                     RdE, RD1E, RegWriteE, ValidE);
        end
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || RdE !== 5'd0) begin
            fails++;
            $display("FAIL stall_flush: got v=%b rw=%b rd=%0d want 0 0 0", ValidE, RegWriteE, RdE);
        end
        checks++;
        if (RD1E !== 32'h1234) begin
            fails++; $display("FAIL flush_data_hold: got %h want 1234", RD1E);
        end
    endtask

    task automatic test_flush_priority();
        drive_all(1'b0);
        ValidD = 1'b1; RegWriteD = 1'b1; JumpD = 1'b1; RdD = 5'd3; Rs1D = 5'd4;
        EnE = 1'b1; FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || JumpE !== 1'b0 || RdE !== 5'd0
            || Rs1E !== 5'd0) begin
            fails++;
            $display("FAIL flush_priority: got v=%b rw=%b j=%b rd=%0d rs1=%0d want all 0",
                     ValidE, RegWriteE, JumpE, RdE, Rs1E);
        end
    endtask

    task automatic test_load_use();
        drive_all(1'b0);
        ValidD = 1'b1; RegWriteD = 1'b1; ResultSrcD = 2'b01; RdD = 5'd7; EnE = 1'b1;
        step();
        ValidD = 1'b0; EnE = 1'b0;
        Rs1D = 5'd3; Rs2D = 5'd7;
        #1;
        checks++;
        if (LoadUseD !== 1'b1) begin
            fails++; $display("FAIL loaduse_rs2: got %b want 1", LoadUseD);
        end
        Rs1D = 5'd7; Rs2D = 5'd2;
        #1;
        checks++;
        if (LoadUseD !== 1'b1) begin
            fails++; $display("FAIL loaduse_rs1: got %b want 1", LoadUseD);
        end
        Rs1D = 5'd6; Rs2D = 5'd8;
        #1;
        checks++;
        if (LoadUseD !== 1'b0) begin
            fails++; $display("FAIL loaduse_nomatch: got %b want 0", LoadUseD);
        end
        // ALU result in EX with a matching register is not a load-use hazard.
        @(posedge clk); #1;
        ValidD = 1'b1; ResultSrcD = 2'b00; RdD = 5'd7; EnE = 1'b1;
        step();
        EnE = 1'b0; Rs1D = 5'd7;
        #1;
        checks++;
        if (LoadUseD !== 1'b0) begin
            fails++; $display("FAIL loaduse_alu: got %b want 0", LoadUseD);
        end
        ValidD = 1'b1; ResultSrcD = 2'b01; RdD = 5'd0; EnE = 1'b1;
        step();
        EnE = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        checks++;
        if (LoadUseD !== 1'b0 || ResultSrcE !== 2'b01) begin
            fails++;
            $display("FAIL loaduse_rd0: got lu=%b rs=%b want 0 01", LoadUseD, ResultSrcE);
        end
    endtask

    task automatic test_bubble_validd();
        drive_all(1'b0);
        ValidD = 1'b0; MemWriteD = 1'b1; RdD = 5'd9; EnE = 1'b1;
        step();
        checks++;
        if (MemWriteE !== 1'b0 || RdE !== 5'd0 || ValidE !== 1'b0) begin
            fails++;
            $display("FAIL bubble_validd: got mw=%b rd=%0d v=%b want 0 0 0", MemWriteE, RdE, ValidE);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rd_vec [4];
        logic [2:0] alu_vec [4];
        rd_vec  = '{5'd1, 5'd2, 5'd31, 5'd17};
        alu_vec = '{3'b000, 3'b001, 3'b101, 3'b011};
        drive_all(1'b0);
        EnE = 1'b1; ValidD = 1'b1; RegWriteD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            RdD = rd_vec[i]; ALUControlD = alu_vec[i]; RD2D = 32'hA000_0000 + i;
            step();
            checks++;
            if (RdE !== rd_vec[i] || ALUControlE !== alu_vec[i] || RD2E !== 32'hA000_0000 + i) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got rd=%0d alu=%b rd2=%h want %0d %b %h", i, RdE,
                         ALUControlE, RD2E, rd_vec[i], alu_vec[i], 32'hA000_0000 + i);
            end
        end
    endtask

    task automatic test_reset_override();
        EnE = 1'b0; FlushE = 1'b1; RdD = 5'd6;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (all_e() !== '0) begin
            fails++; $display("FAIL reset_midflush: got %h want 0", all_e());
        end
        step();
        rst_n = 1'b1; FlushE = 1'b0; EnE = 1'b1; ValidD = 1'b1;
        step();
        checks++;
        if (RdE !== 5'd6 || ValidE !== 1'b1) begin
            fails++; $display("FAIL reset_release_load: got rd=%0d v=%b want 6 1", RdE, ValidE);
        end
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        EnE = 1'b0; FlushE = 1'b0; ValidD = 1'b1;
        checks++;
        if (BubbleCntE !== 32'd0) begin
            fails++; $display("FAIL cnt_reset: got %0d want 0", BubbleCntE);
        end
        FlushE = 1'b1;
        for (int i = 0; i < 3; i++) step();
        FlushE = 1'b0; EnE = 1'b1; ValidD = 1'b0;
        step();
        EnE = 1'b0;
        step();
        step();
        EnE = 1'b1; ValidD = 1'b1;
        step();
        EnE = 1'b0;
        checks++;
        if (BubbleCntE !== 32'd4) begin
            fails++; $display("FAIL cnt_four: got %0d want 4", BubbleCntE);
        end
        dut.bubble_cnt_q <= 32'hFFFF_FFFD;
        step();
        FlushE = 1'b1;
        for (int i = 0; i < 4; i++) step();
        FlushE = 1'b0;
        checks++;
        if (BubbleCntE !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL cnt_saturate: got %h want ffffffff", BubbleCntE);
        end
    endtask
`endif

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        EnE    = 1'b0;
        FlushE = 1'b0;
        drive_all(1'b0);
        test_reset();
        test_load();
        test_stall_flush();
        test_flush_priority();
        test_load_use();
        test_bubble_validd();
        test_back_to_back();
        test_reset_override();
`ifdef IDEX_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
